// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment vectors are bit 0 = a ... bit 6 = g, active-high.
package seg_scan_ctrl_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side data/strobe inputs and display-pin outputs of the scan controller.
// master = host/board side, slave = controller side.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    import seg_scan_ctrl_pkg::*;

    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                lz_en;
    logic [SEG_W-1:0]    SEG;
    logic                DP;
    logic [DIGITS-1:0]   DIG;
    logic                pending;
    logic                frame;

    modport master (
        output data, dp_in, load, lz_en,
        input  SEG, DP, DIG, pending, frame
    );

    modport slave (
        input  data, dp_in, load, lz_en,
        output SEG, DP, DIG, pending, frame
    );

endinterface

// File: rtl/seg_scan_ctrl_dec.sv
// SEG_static: combinational hex-to-7-segment decoder, 0-F, active-high.
// Zero latency; no handshake.
module SEG_static (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b0000000;
        case (i_hex)
            4'h0: o_seg = 7'b0111111;
            4'h1: o_seg = 7'b0000110;
            4'h2: o_seg = 7'b1011011;
            4'h3: o_seg = 7'b1001111;
            4'h4: o_seg = 7'b1100110;
            4'h5: o_seg = 7'b1101101;
            4'h6: o_seg = 7'b1111101;
            4'h7: o_seg = 7'b0000111;
            4'h8: o_seg = 7'b1111111;
            4'h9: o_seg = 7'b1101111;
            4'hA: o_seg = 7'b1110111;
            4'hB: o_seg = 7'b1111100;
            4'hC: o_seg = 7'b0111001;
            4'hD: o_seg = 7'b1011110;
            4'hE: o_seg = 7'b1111001;
            4'hF: o_seg = 7'b1110001;
            default: o_seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan with per-slot blanking and frame-aligned double buffering.
// All outputs registered; SEG valid one clock into a slot; no backpressure, load is a fire-and-forget strobe.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000,
    parameter int BLANK    = 8
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_ctrl_if.slave     bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = idx_width(DIGITS);
    localparam int WORD_W = 4 * DIGITS;

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    slot_state_t       r_state;
    logic [WORD_W-1:0] r_disp_dat;
    logic [DIGITS-1:0] r_disp_dp;
    logic [WORD_W-1:0] r_sh_dat;
    logic [DIGITS-1:0] r_sh_dp;
    logic              r_pend;
    logic [SEG_W-1:0]  r_seg;
    logic              r_dp;
    logic [DIGITS-1:0] r_dig;
    logic              r_frame;

    slot_state_t       w_state_nxt;
    logic              w_slot_end;
    logic              w_frame_end;
    logic [DIGITS-1:0] w_lz;
    logic              w_zero_run;
    logic [3:0]        w_nib;
    logic              w_dp_sel;
    logic              w_blank_sel;
    logic [SEG_W-1:0]  w_dec;

    always_comb begin
        w_slot_end  = (r_cnt == CNT_W'(TICK_DIV - 1));
        w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
        w_state_nxt = r_state;
        case (r_state)
            ST_BLANK: if (r_cnt == CNT_W'(BLANK - 1)) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_slot_end)                 w_state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // A load landing on the frame-end edge skips the shadow so it shows on the very next slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_dat <= '0;
            r_disp_dp  <= '0;
            r_sh_dat   <= '0;
            r_sh_dp    <= '0;
            r_pend     <= 1'b0;
        end else if (bus.load && w_frame_end) begin
            r_disp_dat <= bus.data;
            r_disp_dp  <= bus.dp_in;
            r_pend     <= 1'b0;
        end else if (bus.load) begin
            r_sh_dat <= bus.data;
            r_sh_dp  <= bus.dp_in;
            r_pend   <= 1'b1;
        end else if (w_frame_end && r_pend) begin
            r_disp_dat <= r_sh_dat;
            r_disp_dp  <= r_sh_dp;
            r_pend     <= 1'b0;
        end
    end

    always_comb begin
        w_lz        = '0;
        w_zero_run  = 1'b1;
        w_nib       = 4'd0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (r_disp_dat[4*i +: 4] == 4'd0);
            w_lz[i]    = w_zero_run & (i != 0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_disp_dat[4*i +: 4];
                w_dp_sel    = r_disp_dp[i];
                w_blank_sel = bus.lz_en & w_lz[i];
            end
        end
    end

    SEG_static u_dec (
        .i_hex (w_nib),
        .o_seg (w_dec)
    );

    // Segment data is latched on the first edge of the slot, while digits are still dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b0;
            r_dig   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_dig   <= (w_state_nxt == ST_DRIVE) ? (DIGITS'(1) << r_idx) : '0;
            r_frame <= (r_cnt == CNT_W'(TICK_DIV - 2)) && (r_idx == IDX_W'(DIGITS - 1));
            if (r_cnt == '0) begin
                r_seg <= w_blank_sel ? SEG_BLANK : w_dec;
                r_dp  <= w_dp_sel;
            end
        end
    end

    assign bus.SEG     = r_seg;
    assign bus.DP      = r_dp;
    assign bus.DIG     = r_dig;
    assign bus.pending = r_pend;
    assign bus.frame   = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-level reference model plus directed scenarios with literal expectations.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 16;
    localparam int BLANK    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .BLANK    (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic started  = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference state: m_t is the cycle number since reset release.
    int         m_t    = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_sh   = '0;
    logic [3:0]  m_ddp  = '0;
    logic [3:0]  m_sdp  = '0;
    logic        m_pend = 1'b0;
    logic [6:0]  m_seg  = '0;
    logic        m_dp   = 1'b0;
    int          mc, mi;
    logic        mfe;
    int          cc, ci;

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int idx, input logic lz);
        logic [15:0] upper;
        upper = d >> (4 * idx);
        if (lz && idx != 0 && upper == 16'd0) return 7'd0;
        return seg_tab[4'(upper)];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got %0h want %0h", nm, m_t, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_t    = 0;
            m_disp = '0;
            m_sh   = '0;
            m_ddp  = '0;
            m_sdp  = '0;
            m_pend = 1'b0;
            m_seg  = '0;
            m_dp   = 1'b0;
        end else begin
            mc  = m_t % TICK_DIV;
            mi  = (m_t / TICK_DIV) % DIGITS;
            mfe = (mc == TICK_DIV - 1) && (mi == DIGITS - 1);
            if (mc == 0) begin
                m_seg = exp_seg(m_disp, mi, bus.lz_en);
                m_dp  = m_ddp[mi];
            end
            if (bus.load) begin
                if (mfe) begin
                    m_disp = bus.data;
                    m_ddp  = bus.dp_in;
                    m_pend = 1'b0;
                end else begin
                    m_sh   = bus.data;
                    m_sdp  = bus.dp_in;
                    m_pend = 1'b1;
                end
            end else if (mfe && m_pend) begin
                m_disp = m_sh;
                m_ddp  = m_sdp;
                m_pend = 1'b0;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            cc = m_t % TICK_DIV;
            ci = (m_t / TICK_DIV) % DIGITS;
            chk("dig", 32'(bus.DIG), (cc >= BLANK) ? (32'd1 << ci) : 32'd0);
            chk("frame", 32'(bus.frame), 32'((cc == TICK_DIV - 1) && (ci == DIGITS - 1)));
            chk("pending", 32'(bus.pending), 32'(m_pend));
            if (cc != 0) begin
                chk("seg", 32'(bus.SEG), 32'(m_seg));
                chk("dp", 32'(bus.DP), 32'(m_dp));
            end
        end
    end

    task automatic wait_t(input int target);
        int g;
        g = 0;
        while (m_t < target) begin
            @(negedge clk);
            g++;
            if (g > 1000) begin
                n_checks++;
                n_errors++;
                $display("FAIL timeout target=%0d got t=%0d", target, m_t);
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        bus.data  = d;
        bus.dp_in = dp;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    initial begin
        bus.data  = '0;
        bus.dp_in = '0;
        bus.load  = 1'b0;
        bus.lz_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dig", 32'(bus.DIG), 32'd0);
        chk("rst_seg", 32'(bus.SEG), 32'd0);
        chk("rst_dp", 32'(bus.DP), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_frame", 32'(bus.frame), 32'd0);
        rst     = 1'b0;
        started = 1'b1;

        // Scenario 1 and 2: idle scan, then a mid-slot load
        wait_t(4);
        chk("s1_dig4", 32'(bus.DIG), 32'h1);
        chk("s1_seg4", 32'(bus.SEG), 32'h3F);
        wait_t(10);
        do_load(16'h12AF, 4'b0000);
        chk("s2_pend11", 32'(bus.pending), 32'd1);
        wait_t(15);
        chk("s1_dig15", 32'(bus.DIG), 32'h1);
        wait_t(16);
        chk("s1_dig16", 32'(bus.DIG), 32'h0);
        wait_t(20);
        chk("s1_dig20", 32'(bus.DIG), 32'h2);
        chk("s1_seg20", 32'(bus.SEG), 32'h3F);
        wait_t(63);
        chk("s2_pend63", 32'(bus.pending), 32'd1);
        chk("s2_frame63", 32'(bus.frame), 32'd1);
        wait_t(64);
        chk("s2_pend64", 32'(bus.pending), 32'd0);
        wait_t(69);
        chk("s2_d0", 32'(bus.SEG), 32'h71);
        wait_t(85);
        chk("s2_d1", 32'(bus.SEG), 32'h77);
        wait_t(101);
        chk("s2_d2", 32'(bus.SEG), 32'h5B);
        wait_t(117);
        chk("s2_d3", 32'(bus.SEG), 32'h06);

        // Scenario 3: leading-zero blanking with a dp on a blanked digit
        wait_t(130);
        bus.lz_en = 1'b1;
        do_load(16'h0070, 4'b1000);
        wait_t(197);
        chk("s3_d0", 32'(bus.SEG), 32'h3F);
        chk("s3_d0dp", 32'(bus.DP), 32'd0);
        wait_t(213);
        chk("s3_d1", 32'(bus.SEG), 32'h07);
        wait_t(229);
        chk("s3_d2", 32'(bus.SEG), 32'h00);
        wait_t(245);
        chk("s3_d3", 32'(bus.SEG), 32'h00);
        chk("s3_d3dp", 32'(bus.DP), 32'd1);

        // Scenario 4: load on the frame cycle bypasses the shadow
        wait_t(255);
        chk("s4_frame", 32'(bus.frame), 32'd1);
        do_load(16'h5555, 4'b0000);
        chk("s4_pend256", 32'(bus.pending), 32'd0);
        wait_t(257);
        chk("s4_seg257", 32'(bus.SEG), 32'h6D);
        chk("s4_pend257", 32'(bus.pending), 32'd0);

        // Scenario 5: last load in a frame wins
        wait_t(270);
        do_load(16'h1111, 4'b0000);
        wait_t(280);
        do_load(16'h2222, 4'b0000);
        wait_t(309);
        chk("s5_old", 32'(bus.SEG), 32'h6D);
        wait_t(319);
        chk("s5_pend", 32'(bus.pending), 32'd1);
        wait_t(325);
        chk("s5_d0", 32'(bus.SEG), 32'h5B);
        wait_t(341);
        chk("s5_d1", 32'(bus.SEG), 32'h5B);
        wait_t(357);
        chk("s5_d2", 32'(bus.SEG), 32'h5B);
        wait_t(373);
        chk("s5_d3", 32'(bus.SEG), 32'h5B);

        // Scenario 6: asynchronous reset mid-DRIVE with an update pending
        wait_t(390);
        do_load(16'h8888, 4'b1111);
        wait_t(424);
        chk("s6_pre_pend", 32'(bus.pending), 32'd1);
        chk("s6_pre_dig", 32'(bus.DIG), 32'h4);
        #2;
        rst       = 1'b1;
        bus.lz_en = 1'b0;
        #1;
        chk("s6_async_dig", 32'(bus.DIG), 32'd0);
        chk("s6_async_seg", 32'(bus.SEG), 32'd0);
        chk("s6_async_pend", 32'(bus.pending), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_t(5);
        chk("s6_dig5", 32'(bus.DIG), 32'h1);
        chk("s6_seg5", 32'(bus.SEG), 32'h3F);
        chk("s6_pend5", 32'(bus.pending), 32'd0);
        wait_t(21);
        chk("s6_dig21", 32'(bus.DIG), 32'h2);
        chk("s6_seg21", 32'(bus.SEG), 32'h3F);
        wait_t(80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", m_t);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a common-segment 7-segment display bank. It owns the shared segment bus and sequences the `SEG_static` hex-to-segment decoder across `DIGITS` digit enables, one digit per scan slot. Each slot starts with a blanking interval to suppress ghosting. New display words are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new data. It sits between the register/host logic that produces hex values and the board's digit and segment pins.

## Interface
- `DIGITS`, 4: number of digits scanned; 1..8.
- `TICK_DIV`, 1000: clocks per digit slot; must be ≥ 2.
- `BLANK`, 8: clocks at the start of each slot with all digits off; must satisfy 1 ≤ `BLANK` < `TICK_DIV`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `data` in 4·`DIGITS`: hex nibbles; nibble *i* (bits 4i+3:4i) drives digit *i*, with digit 0 least significant.
- `dp_in` in `DIGITS`: decimal-point request per digit.
- `load` in 1: single-cycle strobe that captures `data`/`dp_in` into the shadow register.
- `lz_en` in 1: enables leading-zero blanking.
- `SEG` out 7: segment pattern, bit 0 = a … bit 6 = g, active-high.
- `DP` out 1: decimal point of the active digit, active-high.
- `DIG` out `DIGITS`: one-hot digit enable, active-high.
- `pending` out 1: shadow holds data not yet displayed.
- `frame` out 1: one-cycle pulse on the last clock of each frame.

## Operation
- Internal state:
  - `cnt`, slot counter 0..`TICK_DIV`-1.
  - `idx`, digit index 0..`DIGITS`-1.
  - shadow register and display register, each 4·`DIGITS` + `DIGITS` bits.
  - `pending` flag.
- Two-state slot FSM:
  - BLANK while `cnt` < `BLANK`: `DIG`=0.
  - DRIVE while `cnt` ≥ `BLANK`: `DIG` = 1<<`idx`.
- Slot end (`cnt`=`TICK_DIV`-1):
  - `cnt` returns to 0.
  - `idx` increments, wrapping from `DIGITS`-1 to 0.
- Frame end is the slot end with `idx`=`DIGITS`-1:
  - `frame`=1 for that cycle.
  - If `pending`=1: display ← shadow and `pending` ← 0.
- `load`:
  - shadow ← {`dp_in`, `data`} and `pending` ← 1.
  - A load while `pending`=1 overwrites the shadow; the last load wins.
  - A load in the frame-end cycle writes display directly (bypass) and leaves `pending`=0.
- `SEG` for the slot = decode of display nibble `idx`, using the standard 0–F patterns (0=0111111 … F=1110001). `DP` = display dp bit `idx`.
- Leading-zero blanking (`lz_en`=1):
  - Digit *i* is blanked when nibbles `DIGITS`-1 down to *i* are all zero and *i* ≠ 0.
  - A blanked digit drives `SEG`=0 and its dp bit is still honoured.
  - Digit 0 is never blanked.
- `SEG`/`DP` are updated on entry to the slot, i.e. during BLANK, and held stable through DRIVE.

## Timing
- Reset values, all applied asynchronously:
  - `cnt`=0, `idx`=0, FSM in BLANK.
  - display=0, shadow=0.
  - `DIG`=0, `SEG`=0, `DP`=0, `pending`=0, `frame`=0.
- All outputs are registered.
- After `rst` falls, the first clock edge sees `cnt`=0.
  - `SEG` is valid one clock after slot entry.
  - `DIG` is high for edges `BLANK`..`TICK_DIV`-1 of each slot, i.e. `TICK_DIV`-`BLANK` clocks.
- Frame period = `DIGITS`·`TICK_DIV` clocks.
- Load-to-display latency: between 1 clock (bypass) and one frame plus one slot.
- Reset mid-slot: `DIG` and `SEG` drop to 0 immediately, without waiting for a clock; a pending update is discarded.
- `frame` and `load` in the same cycle: the bypass rule applies; `pending` does not pulse.

## Structure
- Shared include file (`seg_defs.vh`):
  - segment bit-position constants;
  - blank pattern 7'b0000000.
- Sub-module: one instance of the existing `SEG_static` decoder, fed by the `idx`-selected display nibble. Its output is registered in this block.
- Remaining logic in one module:
  - counter;
  - digit FSM;
  - shadow/display registers;
  - leading-zero mask.

## Test plan
All scenarios use `DIGITS`=4, `TICK_DIV`=16, `BLANK`=4.

1. Reset, then release with no load.
   - During reset: all outputs 0.
   - After release: `DIG`=0001 on cycles 4–15 with `SEG`=0111111, then `DIG`=0010 on cycles 20–31.
2. `load` with `data`=16'h12AF at cycle 10.
   - `pending`=1 until the frame-end cycle 63.
   - Next frame:
     - digit 0: `SEG`=1110001;
     - digit 1: `SEG`=1110111;
     - digit 2: `SEG`=1011011;
     - digit 3: `SEG`=0000110.
3. `lz_en`=1, `data`=16'h0070, `dp_in`=4'b1000.
   - Digit 3: `SEG`=0, `DP`=1.
   - Digit 2: `SEG`=0.
   - Digit 1: `SEG`=0000111.
   - Digit 0: `SEG`=0111111.
4. `load` (16'h5555) asserted exactly on the `frame` cycle.
   - `pending` never rises.
   - Digit 0 of the very next slot shows 1101101.
5. Two loads in one frame (16'h1111, then 16'h2222).
   - Only 2222 is ever displayed (1011011 on all digits).
6. `rst` asserted at cycle 40 mid-DRIVE with `pending`=1.
   - `DIG`=0 and `SEG`=0 before the next clock edge.
   - After release: scan restarts at digit 0 with display=0 and `pending`=0.
